ur_cmd_bank: RTL and testbench
==============================

// Module: ur_cmd_bank
// PURPOSE
//  Parametrised successor to the fixed 8x16 user-register latch. Takes the flat SPI user-register
//  vector, qualifies it as stable for STABLE_CYCLES before committing, so multi-byte SPI writes
//  are never captured half-written. Honours an update-disable hold.
//  Reports which fields changed and turns rising CMD bits into one-cycle pulses.
//  Sits between the SPI slave register file and the acquisition/accumulation control logic.
// PARAMETERS
//  N_FIELDS       8   number of fields in user_register_i
//  FIELD_W        16  width of each field, bits
//  STABLE_CYCLES  4   consecutive identical samples required before commit (>=1)
//  CMD_FIELD      0   index of the field whose rising bits generate cmd_pulse_o
// PORTS
//  clk              in   1                  system clock; all logic on posedge
//  rst_n            in   1                  asynchronous active-low reset
//  update_disable   in   1                  1 = hold commits (sync to clk)
//  user_register_i  in   N_FIELDS*FIELD_W   field i = bits [(i+1)*FIELD_W-1 : i*FIELD_W]
//  fields_o         out  N_FIELDS*FIELD_W   committed fields, same packing
//  commit_o         out  1                  1-cycle strobe, fields_o just updated
//  changed_o        out  N_FIELDS           per-field diff vs previous commit; valid with commit_o
//  cmd_pulse_o      out  FIELD_W            rising bits of CMD_FIELD; valid with commit_o
//  pending_o        out  1                  qualified update held by update_disable
//  commit_cnt_o     out  8                  number of commits, wraps 255->0
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; in_q, snap, cnt, fields_o, changed_o, cmd_pulse_o,
//   commit_cnt_o = 0; commit_o = pending_o = 0. Reset mid-operation discards any settle/hold.
//  Every edge: in_q <= user_register_i. Only in_q is compared; the raw input is never used.
//  States:
//   IDLE   : in_q != fields_o -> SETTLE, snap<=in_q, cnt<=0. Else stay.
//   SETTLE : in_q == fields_o -> IDLE, no commit (write reverted).
//            in_q != snap -> snap<=in_q, cnt<=0 (restart).
//            cnt < STABLE_CYCLES-1 -> cnt++.
//            cnt == STABLE_CYCLES-1 -> COMMIT if !update_disable, else HOLD.
//   HOLD   : pending_o=1. in_q != snap -> SETTLE, snap<=in_q, cnt<=0.
//            Else !update_disable -> COMMIT. Else stay.
//   COMMIT : single cycle. On the entering edge: fields_o<=snap.
//            changed_o[i] <= |(snap_i ^ fields_o_i).
//            cmd_pulse_o <= snap_CMD & ~fields_o_CMD.
//            commit_cnt_o++. Then -> IDLE unconditionally.
//  commit_o=1, changed_o and cmd_pulse_o nonzero only while state==COMMIT; zero otherwise.
//  pending_o = (state==HOLD).
//  Latency: input change before edge 1 -> fields_o/commit_o at edge STABLE_CYCLES+2
//   (6 for default), provided update_disable=0.
//  update_disable does not stop settling; it only blocks the COMMIT transition.
//  Dropping update_disable in HOLD commits on the next edge.
//  Input change during COMMIT: detected in IDLE next cycle; new settle starts, none lost.
//  Stable input identical to fields_o never commits; a stuck input commits exactly once.
//  cnt width = $clog2(STABLE_CYCLES+1). Field compares are full-width equality, no arithmetic.
//  Default mapping, field 7..0: nTotalPoints, HighLim_Spec, LowLim_Spec, nRangeBins,
//   nPoints_RB, nACC_Pulses, TriggerLevel, CMD.
// TESTING (defaults)
//  Reset entry/exit: rst_n=0, input all fields 0xA5A5 -> outputs 0; release -> commit_o at
//   edge 6, fields_o all 0xA5A5, changed_o=8'hFF, commit_cnt_o=1.
//  Torn write: field3 -> 0x0100, 2 cycles later 0x0200 -> exactly one commit, 6 edges after
//   second change; fields_o[3]=0x0200, changed_o=8'h08.
//  Hold: update_disable=1, field1 -> 0x0010 -> pending_o=1 from edge 6, fields_o unchanged;
//   disable->0 -> commit_o next edge, pending_o=0, changed_o=8'h02.
//  CMD pulses: CMD 0x0001->0x0003 -> cmd_pulse_o=0x0002 for 1 cycle; 0x0003->0x0001 ->
//   commit with changed_o=8'h01, cmd_pulse_o=0.
//  Revert/abort: field5 changed then restored within 2 cycles -> no commit_o, state IDLE.
//   rst_n pulsed mid-SETTLE -> all outputs 0, no commit until re-qualified.
//  Wrap: 256 distinct commits -> commit_cnt_o goes 255->0 with no other side effect.

Source files
------------

// File: rtl/ur_cmd_bank.sv
// rtl/ur_cmd_bank.sv - stability-qualified user-register commit bank with change report and CMD pulses
module ur_cmd_bank #(
    parameter int N_FIELDS      = 8,
    parameter int FIELD_W       = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int CMD_FIELD     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          update_disable,
    input  logic [N_FIELDS*FIELD_W-1:0]   user_register_i,
    output logic [N_FIELDS*FIELD_W-1:0]   fields_o,
    output logic                          commit_o,
    output logic [N_FIELDS-1:0]           changed_o,
    output logic [FIELD_W-1:0]            cmd_pulse_o,
    output logic                          pending_o,
    output logic [7:0]                    commit_cnt_o
);

    localparam int TOT_W = N_FIELDS * FIELD_W;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [TOT_W-1:0] in_q;
    logic [TOT_W-1:0] snap;
    logic [CNT_W-1:0] cnt;
    logic             load_snap;
    logic             cnt_inc;
    logic             do_commit;
    logic [N_FIELDS-1:0] changed_next;
    logic [FIELD_W-1:0]  cmd_next;

    assign commit_o  = (state == ST_COMMIT);
    assign pending_o = (state == ST_HOLD);

    // Next-state decision; only the registered copy of the input is ever compared.
    always_comb begin
        state_d   = state;
        load_snap = 1'b0;
        cnt_inc   = 1'b0;
        do_commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_q != fields_o) begin
                    state_d   = ST_SETTLE;
                    load_snap = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (in_q == fields_o) begin
                    state_d = ST_IDLE;
                end else if (in_q != snap) begin
                    load_snap = 1'b1;
                end else if (cnt < CNT_LAST) begin
                    cnt_inc = 1'b1;
                end else if (update_disable) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d   = ST_COMMIT;
                    do_commit = 1'b1;
                end
            end
            ST_HOLD: begin
                if (in_q != snap) begin
                    state_d   = ST_SETTLE;
                    load_snap = 1'b1;
                end else if (!update_disable) begin
                    state_d   = ST_COMMIT;
                    do_commit = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-field difference and rising CMD bits between the snapshot and the last committed value.
    always_comb begin
        changed_next = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            changed_next[i] = |(snap[i*FIELD_W +: FIELD_W] ^ fields_o[i*FIELD_W +: FIELD_W]);
        end
        cmd_next = snap[CMD_FIELD*FIELD_W +: FIELD_W] & ~fields_o[CMD_FIELD*FIELD_W +: FIELD_W];
    end

    // Input register, state, snapshot and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            in_q  <= '0;
            snap  <= '0;
            cnt   <= '0;
        end else begin
            in_q  <= user_register_i;
            state <= state_d;
            if (load_snap) begin
                snap <= in_q;
                cnt  <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Committed outputs; change report and CMD pulse live only for the COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_o     <= '0;
            changed_o    <= '0;
            cmd_pulse_o  <= '0;
            commit_cnt_o <= '0;
        end else begin
            changed_o   <= '0;
            cmd_pulse_o <= '0;
            if (do_commit) begin
                fields_o     <= snap;
                changed_o    <= changed_next;
                cmd_pulse_o  <= cmd_next;
                commit_cnt_o <= commit_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ur_cmd_bank.sv
// tb/tb_ur_cmd_bank.sv - directed self-checking bench for ur_cmd_bank
module tb_ur_cmd_bank;

    logic         clk;
    logic         rst_n;
    logic         update_disable;
    logic [127:0] reg_in;
    logic [127:0] fields_o;
    logic         commit_o;
    logic [7:0]   changed_o;
    logic [15:0]  cmd_pulse_o;
    logic         pending_o;
    logic [7:0]   commit_cnt_o;

    int         checks;
    int         errors;
    logic [7:0] exp_cnt;

    ur_cmd_bank #(
        .N_FIELDS(8), .FIELD_W(16), .STABLE_CYCLES(4), .CMD_FIELD(0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .update_disable (update_disable),
        .user_register_i(reg_in),
        .fields_o       (fields_o),
        .commit_o       (commit_o),
        .changed_o      (changed_o),
        .cmd_pulse_o    (cmd_pulse_o),
        .pending_o      (pending_o),
        .commit_cnt_o   (commit_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] fld(input logic [127:0] v, input int i);
        return v[i*16 +: 16];
    endfunction

    task automatic test_reset;
        logic [127:0] all_a5;
        rst_n = 1'b0;
        update_disable = 1'b0;
        for (int i = 0; i < 8; i++) reg_in[i*16 +: 16] = 16'hA5A5;
        all_a5 = reg_in;
        repeat (3) tick;
        checks++;
        if (fields_o !== 128'd0 || commit_o !== 1'b0 || changed_o !== 8'd0 ||
            cmd_pulse_o !== 16'd0 || pending_o !== 1'b0 || commit_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: fields=%h commit=%b changed=%h pulse=%h pend=%b cnt=%0d, required all zero",
                     fields_o, commit_o, changed_o, cmd_pulse_o, pending_o, commit_cnt_o);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick;
            checks++;
            if (commit_o !== (e == 6)) begin
                errors++;
                $display("FAIL reset_exit_commit_edge%0d: commit_o=%b required %b", e, commit_o, (e == 6));
            end
        end
        exp_cnt = 8'd1;
        checks++;
        if (fields_o !== all_a5 || changed_o !== 8'hFF || commit_cnt_o !== exp_cnt || cmd_pulse_o !== 16'hA5A5) begin
            errors++;
            $display("FAIL reset_exit_values: fields=%h changed=%h cnt=%0d pulse=%h, required %h FF 1 A5A5",
                     fields_o, changed_o, commit_cnt_o, cmd_pulse_o, all_a5);
        end
        tick;
        checks++;
        if (commit_o !== 1'b0 || changed_o !== 8'd0 || cmd_pulse_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_exit_strobe_clear: commit=%b changed=%h pulse=%h, required 0 0 0",
                     commit_o, changed_o, cmd_pulse_o);
        end
    endtask

    task automatic test_torn_write;
        int n_commits;
        int commit_at;
        logic [15:0] f3;
        logic [7:0]  chg;
        n_commits = 0;
        commit_at = 0;
        f3  = 16'd0;
        chg = 8'd0;
        reg_in[3*16 +: 16] = 16'h0100;
        tick;
        tick;
        reg_in[3*16 +: 16] = 16'h0200;
        for (int e = 1; e <= 12; e++) begin
            tick;
            if (commit_o) begin
                n_commits++;
                if (commit_at == 0) begin
                    commit_at = e;
                    f3  = fld(fields_o, 3);
                    chg = changed_o;
                end
            end
        end
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (n_commits != 1 || commit_at != 6) begin
            errors++;
            $display("FAIL torn_commit_count: commits=%0d at edge %0d, required 1 at edge 6", n_commits, commit_at);
        end
        checks++;
        if (f3 !== 16'h0200 || chg !== 8'h08 || commit_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL torn_values: field3=%h changed=%h cnt=%0d, required 0200 08 %0d", f3, chg, commit_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_hold;
        update_disable = 1'b1;
        reg_in[1*16 +: 16] = 16'h0010;
        for (int e = 1; e <= 8; e++) begin
            tick;
            checks++;
            if (pending_o !== (e >= 6) || commit_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_pending_edge%0d: pending=%b commit=%b, required %b 0", e, pending_o, commit_o, (e >= 6));
            end
        end
        checks++;
        if (fld(fields_o, 1) !== 16'hA5A5) begin
            errors++;
            $display("FAIL hold_fields_frozen: field1=%h required A5A5", fld(fields_o, 1));
        end
        update_disable = 1'b0;
        tick;
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (commit_o !== 1'b1 || pending_o !== 1'b0 || changed_o !== 8'h02 ||
            fld(fields_o, 1) !== 16'h0010 || commit_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL hold_release: commit=%b pending=%b changed=%h field1=%h cnt=%0d, required 1 0 02 0010 %0d",
                     commit_o, pending_o, changed_o, fld(fields_o, 1), commit_cnt_o, exp_cnt);
        end
        tick;
    endtask

    task automatic test_cmd_pulse;
        logic [15:0] cmd_vals [3];
        logic [15:0] exp_pulse [3];
        logic        found;
        cmd_vals[0] = 16'h0001; exp_pulse[0] = 16'h0000;
        cmd_vals[1] = 16'h0003; exp_pulse[1] = 16'h0002;
        cmd_vals[2] = 16'h0001; exp_pulse[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            reg_in[15:0] = cmd_vals[k];
            found = 1'b0;
            for (int e = 0; e < 12 && !found; e++) begin
                tick;
                if (commit_o) found = 1'b1;
            end
            exp_cnt = exp_cnt + 8'd1;
            checks++;
            if (!found || cmd_pulse_o !== exp_pulse[k] || changed_o !== 8'h01 || commit_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL cmd_step%0d: found=%b pulse=%h changed=%h cnt=%0d, required 1 %h 01 %0d",
                         k, found, cmd_pulse_o, changed_o, commit_cnt_o, exp_pulse[k], exp_cnt);
            end
            tick;
            checks++;
            if (cmd_pulse_o !== 16'd0 || commit_o !== 1'b0) begin
                errors++;
                $display("FAIL cmd_pulse_width%0d: pulse=%h commit=%b, required 0000 0", k, cmd_pulse_o, commit_o);
            end
        end
    endtask

    task automatic test_revert;
        logic saw;
        int   commit_at;
        reg_in[5*16 +: 16] = 16'h1234;
        tick;
        tick;
        reg_in[5*16 +: 16] = 16'hA5A5;
        saw = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick;
            if (commit_o || pending_o) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || commit_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL revert_no_commit: saw=%b cnt=%0d, required 0 %0d", saw, commit_cnt_o, exp_cnt);
        end
        reg_in[5*16 +: 16] = 16'h5555;
        commit_at = 0;
        for (int e = 1; e <= 8; e++) begin
            tick;
            if (commit_o && commit_at == 0) commit_at = e;
        end
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (commit_at != 6 || fld(fields_o, 5) !== 16'h5555 || commit_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL revert_then_idle_latency: edge=%0d field5=%h cnt=%0d, required 6 5555 %0d",
                     commit_at, fld(fields_o, 5), commit_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_settle;
        int commit_at;
        reg_in[5*16 +: 16] = 16'h1111;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fields_o !== 128'd0 || commit_cnt_o !== 8'd0 || commit_o !== 1'b0 || pending_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: fields=%h cnt=%0d commit=%b pending=%b, required all zero",
                     fields_o, commit_cnt_o, commit_o, pending_o);
        end
        tick;
        rst_n = 1'b1;
        commit_at = 0;
        for (int e = 1; e <= 8; e++) begin
            tick;
            if (commit_o && commit_at == 0) begin
                commit_at = e;
                checks++;
                if (changed_o !== 8'hFF || cmd_pulse_o !== 16'h0001 || fields_o !== reg_in || commit_cnt_o !== 8'd1) begin
                    errors++;
                    $display("FAIL mid_reset_recommit_values: changed=%h pulse=%h cnt=%0d fields=%h, required FF 0001 1 %h",
                             changed_o, cmd_pulse_o, commit_cnt_o, fields_o, reg_in);
                end
            end
        end
        exp_cnt = 8'd1;
        checks++;
        if (commit_at != 6) begin
            errors++;
            $display("FAIL mid_reset_requalify: commit edge=%0d required 6", commit_at);
        end
    endtask

    task automatic test_wrap;
        logic found;
        logic wrapped;
        wrapped = 1'b0;
        for (int i = 0; i < 256; i++) begin
            reg_in[6*16 +: 16] = 16'h2000 + 16'(i);
            found = 1'b0;
            for (int e = 0; e < 12 && !found; e++) begin
                tick;
                if (commit_o) found = 1'b1;
            end
            exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt == 8'd0) wrapped = 1'b1;
            checks++;
            if (!found || commit_cnt_o !== exp_cnt || changed_o !== 8'h40 || cmd_pulse_o !== 16'd0 ||
                fld(fields_o, 6) !== (16'h2000 + 16'(i))) begin
                errors++;
                $display("FAIL wrap_commit%0d: found=%b cnt=%0d changed=%h pulse=%h field6=%h, required 1 %0d 40 0000 %h",
                         i, found, commit_cnt_o, changed_o, cmd_pulse_o, fld(fields_o, 6), exp_cnt, 16'h2000 + 16'(i));
            end
            tick;
        end
        checks++;
        if (wrapped !== 1'b1 || commit_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL wrap_final: wrapped=%b cnt=%0d, required 1 1", wrapped, commit_cnt_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 8'd0;
        rst_n = 1'b0;
        update_disable = 1'b0;
        reg_in = '0;
        test_reset;
        test_torn_write;
        test_hold;
        test_cmd_pulse;
        test_revert;
        test_reset_mid_settle;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
